la_idiff_seq: RTL

//  Power-up sequencer and fault monitor for a bank of N differential input receivers.
//  - Enables receivers one lane at a time, waiting a settle time after each enable.
//  - Watches each enabled pair for loss of differential signalling (in == inb) and latches a sticky fault.
//  - Sits between the pad ring (receiver enables and raw pairs) and core logic (gated, synchronized data).

---
 rtl/la_idiff_pkg.sv | 15 +
 rtl/la_idiff_seq_if.sv | 24 ++
 rtl/la_idiff_mon.sv | 55 +++++
 rtl/la_idiff_seq.sv | 111 +++++++++++
 4 files changed

// File: rtl/la_idiff_pkg.sv
// Shared types for the differential-receiver sequencer: FSM encoding and width helpers.
package la_idiff_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENABLE = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/la_idiff_seq_if.sv
// Pad-side and core-side signals of the receiver sequencer, bundled per lane group.
interface la_idiff_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] clear;
    logic [N-1:0] in;
    logic [N-1:0] inb;
    logic [N-1:0] en;
    logic         busy;
    logic         ready;
    logic [N-1:0] fault;
    logic [N-1:0] z;

    modport master (
        output start, clear, in, inb,
        input  en, busy, ready, fault, z
    );

    modport slave (
        input  start, clear, in, inb,
        output en, busy, ready, fault, z
    );
endinterface

// File: rtl/la_idiff_mon.sv
// Single-lane monitor: synchronizes the pair, counts in==inb runs, latches a sticky fault.
// Latency: fault sets on the edge cnt reaches FAULTCNT; z is one cycle behind the synced sample.
// No backpressure: clear is a write-1 pulse and wins over a simultaneous set.
module la_idiff_mon #(
    parameter int FAULTCNT = 8,
    parameter int SYNC     = 2,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic in,
    input  logic inb,
    input  logic en,
    input  logic act,
    input  logic clear,
    output logic fault,
    output logic z
);
    logic [SYNC-1:0] sp, sn;
    logic            si, sib;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            fault_nxt;

    assign si  = sp[SYNC-1];
    assign sib = sn[SYNC-1];

    always_comb begin
        cnt_nxt   = '0;
        fault_nxt = fault;
        if (act && !clear && (si == sib)) begin
            cnt_nxt = (cnt == CW'(FAULTCNT)) ? cnt : cnt + CW'(1);
        end
        if (clear) begin
            fault_nxt = 1'b0;
        end else if (cnt_nxt == CW'(FAULTCNT)) begin
            fault_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sp    <= '0;
            sn    <= '0;
            cnt   <= '0;
            fault <= 1'b0;
            z     <= 1'b0;
        end else begin
            sp    <= {sp[SYNC-2:0], in};
            sn    <= {sn[SYNC-2:0], inb};
            cnt   <= cnt_nxt;
            fault <= fault_nxt;
            z     <= si & en & ~fault;
        end
    end
endmodule

// File: rtl/la_idiff_seq.sv
// Power-up sequencer enabling N differential receivers one by one, plus per-lane fault monitors.
// Latency: ready rises N*(SETTLE+1)+1 cycles after start; z trails the pads by SYNC+1 cycles.
// No backpressure: start restarts the sequence from any state; faults survive a restart.
module la_idiff_seq #(
    parameter int N        = 4,
    parameter int SETTLE   = 16,
    parameter int FAULTCNT = 8,
    parameter int SYNC     = 2
) (
    input  logic           clk,
    input  logic           nreset,
    la_idiff_seq_if.slave  io
);
    import la_idiff_pkg::*;

    localparam int CW = $clog2(max_int(SETTLE, FAULTCNT) + 1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    state_t        state, state_nxt;
    logic [LW-1:0] lane, lane_nxt;
    logic [CW-1:0] scnt, scnt_nxt;
    logic [N-1:0]  en_q, en_nxt;
    logic          busy_q, busy_nxt;
    logic          ready_q, ready_nxt;
    logic [N-1:0]  act, fault_v, z_v;

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        scnt_nxt  = scnt;
        en_nxt    = en_q;
        busy_nxt  = busy_q;
        ready_nxt = ready_q;
        case (state)
            S_ENABLE: begin
                en_nxt[lane] = 1'b1;
                scnt_nxt     = CW'(SETTLE - 1);
                state_nxt    = S_SETTLE;
            end
            S_SETTLE: begin
                if (scnt != '0) begin
                    scnt_nxt = scnt - CW'(1);
                end else if (lane == LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    lane_nxt  = lane + LW'(1);
                    state_nxt = S_ENABLE;
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
            default: ;
        endcase
        // start takes precedence in every state, including a restart mid-sequence
        if (io.start) begin
            state_nxt = S_ENABLE;
            lane_nxt  = '0;
            en_nxt    = '0;
            busy_nxt  = 1'b1;
            ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= S_IDLE;
            lane    <= '0;
            scnt    <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            lane    <= lane_nxt;
            scnt    <= scnt_nxt;
            en_q    <= en_nxt;
            busy_q  <= busy_nxt;
            ready_q <= ready_nxt;
        end
    end

    // A lane is monitored only once its own settle time has elapsed.
    for (genvar i = 0; i < N; i++) begin : g_mon
        assign act[i] = en_q[i] && ((lane > LW'(i)) || (state == S_DONE));

        la_idiff_mon #(
            .FAULTCNT (FAULTCNT),
            .SYNC     (SYNC),
            .CW       (CW)
        ) u_mon (
            .clk    (clk),
            .nreset (nreset),
            .in     (io.in[i]),
            .inb    (io.inb[i]),
            .en     (en_q[i]),
            .act    (act[i]),
            .clear  (io.clear[i]),
            .fault  (fault_v[i]),
            .z      (z_v[i])
        );
    end

    assign io.en    = en_q;
    assign io.busy  = busy_q;
    assign io.ready = ready_q;
    assign io.fault = fault_v;
    assign io.z     = z_v;
endmodule
